ym3438_op_mod: RTL and testbench
================================

# ym3438_op_mod

Per-slot phase-modulation stage sitting directly downstream of the phase generator and upstream of the operator sine/envelope pipeline. Each slot step it takes the 10-bit operator phase (`pg_in`) and adds a modulation term. For operator 1 the term comes from self-feedback; for operators 2-4 it comes from the stored outputs of modulating operators, selected by the channel's FM algorithm. It keeps a per-channel history of operator outputs written back by the operator pipeline.

## Interface
Parameters: none.

- `MCLK`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset; sampled on `MCLK` rising edge regardless of `c2`.
- `c2`  in  1  slot-step enable; all state (except reset) updates only on `MCLK` edges with `c2`=1 ("step").
- `sync`  in  1  when 1 on a step, that step is slot 0.
- `pg_in`  in  10  phase for the current slot.
- `algorithm`  in  3  FM algorithm of the current slot's channel.
- `fb`  in  3  feedback level of the current slot's channel.
- `op_wr`  in  1  operator-output write strobe, qualified by step.
- `op_wr_slot`  in  5  slot whose output is being written (0-23).
- `op_wr_val`  in  14  signed operator output.
- `phase_out`  out  10  modulated phase (registered).
- `slot_out`  out  5  slot number that `phase_out` belongs to.

## Operation
- **Slot counter.** 5 bits, 0..23.
  - Current slot = 0 if `sync`=1, else the counter value.
  - After each step the counter loads current+1, wrapping 23->0.
- **Slot mapping.** Slots 0-5 are op1 ch0-5; 6-11 are op3; 12-17 are op2; 18-23 are op4. ch = slot mod 6.
- **Storage, per channel (6 ch).**
  - `op1_p0` and `op1_p1` (newest and previous op1 outputs).
  - `op2_l` and `op3_l`.
  - All are 14-bit signed.
- **Write on step with `op_wr`=1.**
  - op1 slot: `op1_p1`<=`op1_p0`, `op1_p0`<=`op_wr_val`.
  - op2 or op3 slot: store into `op2_l` or `op3_l`.
  - op4 slot, or `op_wr_slot` > 23: ignored.
- **Modulation sources (unlisted = 0).**
  - op1: feedback only.
  - op2: op1 for alg 0, 3, 4, 5, 6.
  - op3: op2 for alg 0 and 2; op1+op2 for alg 1; op1 for alg 5.
  - op4: op3 for alg 0, 1, 4; op1+op3 for alg 2; op2+op3 for alg 3; op1 for alg 5.
  - "op1" as a source means `op1_p0`.
- **Arithmetic.**
  - Sources are sign-extended to 15 bits and summed.
  - op2-4: mod = sum >>> 1.
  - op1: mod = (`op1_p0`+`op1_p1`) >>> (10-`fb`) if `fb`≠0, else 0.
  - phase = (`pg_in` + mod) mod 1024, i.e. the low 10 bits of the two's-complement sum.
- **Read/write ordering.** Reads use stored values before this step's write (write-first is forbidden).

## Timing
- **Reset values.** On `reset`: counter=0, all storage=0, `phase_out`=0, `slot_out`=0. Reset overrides `c2`, `sync` and `op_wr`.
- **Latency.** Inputs at step k (slot s) appear on `phase_out`/`slot_out` after that edge. They hold until the next step (1-step latency).
- **Write visibility.** A write at step k is visible to reads at step k+1 onward.
- **Non-step edges.** Edges with `c2`=0 change nothing.
- **`sync` mid-frame.** Restarts the count immediately; there is no other realignment.

## Test plan
- **Reset.** Assert `reset` 2 cycles with `c2`=1 and random inputs -> `phase_out`=0, `slot_out`=0. The next step with `sync`=0 reports slot 0.
- **Alg 0, op2.** Write op1 ch0=200 (slot 0). At slot 12, `pg_in`=100 -> `phase_out`=200.
- **Feedback.** Write op1 ch2=400, then 600. At slot 2 with `fb`=7, `pg_in`=0 -> 125. Same with `fb`=0 -> 0.
- **Negative wrap.** Alg 1: op1 ch1=-300, op2 ch1=-100. At slot 7, `pg_in`=50 -> `phase_out`=874.
- **No modulation.** Alg 7 at slot 18 with all storage nonzero, `pg_in`=321 -> 321.
- **Counter wrap / bad write.** 23->0 wrap after 24 steps. `sync` at counter=10 -> `slot_out`=0 then 1. A write to slot 25 or 20 leaves storage unchanged.

Source files
------------

// File: rtl/ym3438_op_mod_if.sv
// Slot-step bus for the operator phase-modulation stage: slot-step phase in,
// operator-output write-back, and the registered modulated phase out.
interface ym3438_op_mod_if;
    logic        c2;
    logic        sync;
    logic [9:0]  pg_in;
    logic [2:0]  algorithm;
    logic [2:0]  fb;
    logic        op_wr;
    logic [4:0]  op_wr_slot;
    logic [13:0] op_wr_val;
    logic [9:0]  phase_out;
    logic [4:0]  slot_out;

    modport master (
        output c2, sync, pg_in, algorithm, fb, op_wr, op_wr_slot, op_wr_val,
        input  phase_out, slot_out
    );

    modport slave (
        input  c2, sync, pg_in, algorithm, fb, op_wr, op_wr_slot, op_wr_val,
        output phase_out, slot_out
    );
endinterface

// File: rtl/ym3438_op_mod.sv
// Per-slot phase modulation: adds op1 self-feedback or algorithm-selected
// modulator outputs to the phase, keeping a per-channel operator-output history.

// One channel's operator-output history.
module ym3438_op_mod_ch (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_op1,
    input  logic        wr_op2,
    input  logic        wr_op3,
    input  logic [13:0] wr_val,
    output logic [13:0] op1_p0,
    output logic [13:0] op1_p1,
    output logic [13:0] op2_l,
    output logic [13:0] op3_l
);
    always_ff @(posedge clk) begin
        if (reset) begin
            op1_p0 <= '0;
            op1_p1 <= '0;
            op2_l  <= '0;
            op3_l  <= '0;
        end else begin
            if (wr_op1) begin
                op1_p1 <= op1_p0;
                op1_p0 <= wr_val;
            end
            if (wr_op2) op2_l <= wr_val;
            if (wr_op3) op3_l <= wr_val;
        end
    end
endmodule

module ym3438_op_mod (
    input  logic               MCLK,
    input  logic               reset,
    ym3438_op_mod_if.slave     bus
);
    localparam int NUM_CH = 6;

    typedef enum logic [1:0] {OP1, OP2, OP3, OP4} op_e;

    // Slot order within a frame is op1, op3, op2, op4 (six channels each).
    function automatic op_e slot_op(input logic [4:0] s);
        if (s < 5'd6)       return OP1;
        else if (s < 5'd12) return OP3;
        else if (s < 5'd18) return OP2;
        else                return OP4;
    endfunction

    function automatic logic [2:0] slot_ch(input logic [4:0] s);
        logic [4:0] t;
        if (s < 5'd6)       t = s;
        else if (s < 5'd12) t = s - 5'd6;
        else if (s < 5'd18) t = s - 5'd12;
        else                t = s - 5'd18;
        return t[2:0];
    endfunction

    logic       step;
    logic [4:0] cnt;
    logic [4:0] cur_slot;
    op_e        cur_op;
    logic [2:0] cur_ch;

    assign step     = bus.c2;
    assign cur_slot = bus.sync ? 5'd0 : cnt;
    assign cur_op   = slot_op(cur_slot);
    assign cur_ch   = slot_ch(cur_slot);

    // Write decode; op4 slots and out-of-range slots select nothing.
    logic       wr_hit;
    op_e        wr_op;
    logic [2:0] wr_ch;

    assign wr_hit = step && bus.op_wr && (bus.op_wr_slot < 5'd24);
    assign wr_op  = slot_op(bus.op_wr_slot);
    assign wr_ch  = slot_ch(bus.op_wr_slot);

    logic [NUM_CH-1:0][13:0] p0_a, p1_a, op2_a, op3_a;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_hit && (wr_ch == 3'(i));
        ym3438_op_mod_ch u_ch (
            .clk    (MCLK),
            .reset  (reset),
            .wr_op1 (sel && (wr_op == OP1)),
            .wr_op2 (sel && (wr_op == OP2)),
            .wr_op3 (sel && (wr_op == OP3)),
            .wr_val (bus.op_wr_val),
            .op1_p0 (p0_a[i]),
            .op1_p1 (p1_a[i]),
            .op2_l  (op2_a[i]),
            .op3_l  (op3_a[i])
        );
    end

    // Reads see the pre-write registers, so a same-step write is invisible here.
    logic [13:0] r_p0, r_p1, r_op2, r_op3;

    always_comb begin
        r_p0  = '0;
        r_p1  = '0;
        r_op2 = '0;
        r_op3 = '0;
        if (cur_ch < 3'(NUM_CH)) begin
            r_p0  = p0_a[cur_ch];
            r_p1  = p1_a[cur_ch];
            r_op2 = op2_a[cur_ch];
            r_op3 = op3_a[cur_ch];
        end
    end

    logic signed [14:0] e_p0, e_p1, e_op2, e_op3;
    assign e_p0  = {r_p0[13],  r_p0};
    assign e_p1  = {r_p1[13],  r_p1};
    assign e_op2 = {r_op2[13], r_op2};
    assign e_op3 = {r_op3[13], r_op3};

    logic               use_op1, use_op2, use_op3;
    logic signed [14:0] src_sum, fb_sum, mod;
    logic [3:0]         fb_sh;
    logic [9:0]         phase;

    always_comb begin
        use_op1 = 1'b0;
        use_op2 = 1'b0;
        use_op3 = 1'b0;
        case (cur_op)
            OP2: use_op1 = bus.algorithm inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
            OP3: begin
                use_op2 = bus.algorithm inside {3'd0, 3'd1, 3'd2};
                use_op1 = bus.algorithm inside {3'd1, 3'd5};
            end
            OP4: begin
                use_op3 = bus.algorithm inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
                use_op1 = bus.algorithm inside {3'd2, 3'd5};
                use_op2 = bus.algorithm == 3'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        src_sum = (use_op1 ? e_p0  : 15'sd0)
                + (use_op2 ? e_op2 : 15'sd0)
                + (use_op3 ? e_op3 : 15'sd0);
        fb_sum  = e_p0 + e_p1;
        fb_sh   = 4'd10 - {1'b0, bus.fb};
        if (cur_op == OP1)
            mod = (bus.fb == 3'd0) ? 15'sd0 : (fb_sum >>> fb_sh);
        else
            mod = src_sum >>> 1;
        // Only the low 10 bits matter: the phase wraps modulo 1024.
        phase = bus.pg_in + mod[9:0];
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            cnt           <= '0;
            bus.phase_out <= '0;
            bus.slot_out  <= '0;
        end else if (step) begin
            cnt           <= (cur_slot == 5'd23) ? 5'd0 : cur_slot + 5'd1;
            bus.phase_out <= phase;
            bus.slot_out  <= cur_slot;
        end
    end
endmodule

// File: tb/tb_ym3438_op_mod.sv
// Directed bench for ym3438_op_mod: one frame of table vectors plus sequences
// for sync realignment, idle edges and reset.
module tb_ym3438_op_mod;
    logic MCLK;
    logic reset;
    ym3438_op_mod_if bus ();

    ym3438_op_mod dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    typedef struct {
        logic        sync;
        logic [9:0]  pg;
        logic [2:0]  alg;
        logic [2:0]  fb;
        logic        wr;
        logic [4:0]  ws;
        logic [13:0] wv;
        logic [9:0]  ep;
        logic [4:0]  es;
    } vec_t;

    vec_t tbl[28];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t mk(input int sync, input int pg, input int alg, input int fb,
                                input int wr, input int ws, input int wv,
                                input int ep, input int es);
        vec_t v;
        v.sync = 1'(sync); v.pg = 10'(pg); v.alg = 3'(alg); v.fb = 3'(fb);
        v.wr = 1'(wr); v.ws = 5'(ws); v.wv = 14'(wv);
        v.ep = 10'(ep); v.es = 5'(es);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic c2, input logic sync, input logic [9:0] pg,
                         input logic [2:0] alg, input logic [2:0] fb, input logic wr,
                         input logic [4:0] ws, input logic [13:0] wv);
        bus.c2 = c2; bus.sync = sync; bus.pg_in = pg; bus.algorithm = alg;
        bus.fb = fb; bus.op_wr = wr; bus.op_wr_slot = ws; bus.op_wr_val = wv;
        @(posedge MCLK);
        #1;
    endtask

    task automatic step_chk(input string name, input logic sync, input logic [9:0] pg,
                            input logic [2:0] alg, input logic [2:0] fb,
                            input int ep, input int es);
        drive(1'b1, sync, pg, alg, fb, 1'b0, 5'd0, 14'd0);
        chk({name, " phase"}, int'(bus.phase_out), ep);
        chk({name, " slot"},  int'(bus.slot_out),  es);
    endtask

    initial begin
        // Fillers use alg 7 / fb 0 so the phase passes through unmodulated.
        tbl[0]  = mk(0,   5, 7, 0, 1,  0,  200,   5,  0);
        tbl[1]  = mk(0,   1, 7, 0, 1,  1, -300,   1,  1);
        tbl[2]  = mk(0,   0, 7, 0, 1,  2,  400,   0,  2);
        tbl[3]  = mk(0,   3, 7, 0, 1,  2,  600,   3,  3);
        tbl[4]  = mk(0,   4, 7, 0, 1, 13, -100,   4,  4);
        tbl[5]  = mk(0,   5, 7, 0, 1, 25,  999,   5,  5);
        tbl[6]  = mk(0,   6, 7, 0, 1, 20,  777,   6,  6);
        tbl[7]  = mk(0,  50, 1, 0, 0,  0,    0, 874,  7);
        tbl[8]  = mk(0,   8, 7, 0, 1,  6,   40,   8,  8);
        tbl[9]  = mk(0,   9, 7, 0, 1, 12,   60,   9,  9);
        tbl[10] = mk(0,  10, 7, 0, 0,  0,    0,  10, 10);
        tbl[11] = mk(0,  11, 7, 0, 0,  0,    0,  11, 11);
        tbl[12] = mk(0, 100, 0, 0, 0,  0,    0, 200, 12);
        tbl[13] = mk(0,  10, 0, 0, 0,  0,    0, 884, 13);
        tbl[14] = mk(0,  14, 7, 0, 0,  0,    0,  14, 14);
        tbl[15] = mk(0,  15, 7, 0, 0,  0,    0,  15, 15);
        tbl[16] = mk(0,  16, 7, 0, 0,  0,    0,  16, 16);
        tbl[17] = mk(0,  17, 7, 0, 0,  0,    0,  17, 17);
        tbl[18] = mk(0, 321, 7, 0, 0,  0,    0, 321, 18);
        tbl[19] = mk(0, 100, 3, 0, 0,  0,    0,  50, 19);
        tbl[20] = mk(0,   0, 5, 0, 0,  0,    0, 300, 20);
        tbl[21] = mk(0,  21, 7, 0, 0,  0,    0,  21, 21);
        tbl[22] = mk(0,  22, 7, 0, 0,  0,    0,  22, 22);
        tbl[23] = mk(0,  23, 7, 0, 0,  0,    0,  23, 23);
        tbl[24] = mk(0,   0, 7, 7, 0,  0,    0,  25,  0);
        tbl[25] = mk(0,   0, 7, 1, 0,  0,    0, 1023, 1);
        tbl[26] = mk(0,   0, 7, 7, 1,  2, 1000, 125,  2);
        tbl[27] = mk(0,   3, 7, 0, 0,  0,    0,   3,  3);

        reset = 1'b1;
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'($urandom), 10'($urandom), 3'($urandom), 3'($urandom),
                  1'b1, 5'($urandom_range(0, 23)), 14'($urandom));
        chk("reset phase", int'(bus.phase_out), 0);
        chk("reset slot",  int'(bus.slot_out),  0);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            drive(1'b1, tbl[i].sync, tbl[i].pg, tbl[i].alg, tbl[i].fb,
                  tbl[i].wr, tbl[i].ws, tbl[i].wv);
            chk($sformatf("v%0d phase", i), int'(bus.phase_out), int'(tbl[i].ep));
            chk($sformatf("v%0d slot", i),  int'(bus.slot_out),  int'(tbl[i].es));
        end

        // Run the counter up to 10, then sync mid-frame.
        for (int s = 4; s < 10; s++)
            step_chk($sformatf("run s%0d", s), 1'b0, 10'(s), 3'd7, 3'd0, s, s);
        step_chk("sync",       1'b1, 10'd7, 3'd7, 3'd0, 7, 0);
        step_chk("after sync", 1'b0, 10'd9, 3'd7, 3'd0, 9, 1);
        // op1 ch2 history is now 1000/600: (1600 >>> 3) = 200.
        step_chk("fb visible", 1'b0, 10'd0, 3'd7, 3'd7, 200, 2);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 10'd55, 3'd0, 3'd7, 1'b1, 5'd2, 14'd5);
            chk($sformatf("idle%0d phase", i), int'(bus.phase_out), 200);
            chk($sformatf("idle%0d slot", i),  int'(bus.slot_out),  2);
        end
        step_chk("post idle", 1'b0, 10'd3, 3'd7, 3'd0, 3, 3);

        reset = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 3'd0, 3'd0, 1'b0, 5'd0, 14'd0);
        chk("reset2 phase", int'(bus.phase_out), 0);
        chk("reset2 slot",  int'(bus.slot_out),  0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
